decode_unit: RTL and testbench

Parametrised, multi-lane successor to the single-instruction decoder. Accepts a bundle of up to `DECODE_WIDTH` fetched instructions per cycle over a valid/ready handshake and decodes each lane into an `ISSUE_QUEUE_ELEMENT` plus an illegal-instruction flag. Results are registered, and a one-bundle skid buffer keeps `in_ready` fully registered. Sits between fetch and the issue queue, and honours pipeline flush.

---
 rtl/decode_unit_pkg.sv | 63 ++++++
 rtl/decode_unit_lane.sv | 77 +++++++
 rtl/decode_unit.sv | 114 +++++++++++
 tb/tb_decode_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/decode_unit_pkg.sv
// Shared types and constants for the multi-lane decoder: fetch bundle lane,
// issue queue element, ALU/branch/memory enums and MIPS opcode/funct codes.
package decode_unit_pkg;

    typedef enum logic [1:0] {arithmatic, brunch, memory, llu} exe_type_t;
    typedef enum logic [1:0] {nbc, bc_eq, bc_ne, bc_jmp} brunch_type_t;
    typedef enum logic [1:0] {llu_nop, llu_mul, llu_div, llu_divu} llu_op_t;
    typedef enum logic [2:0] {alu_or, alu_add, alu_sub, alu_and, alu_xor, alu_slt} alu_op_t;
    typedef enum logic [1:0] {wrd, hwd, byt} mem_type_t;

    localparam logic [5:0] op_special = 6'b000000;
    localparam logic [5:0] op_addiu   = 6'b001001;
    localparam logic [5:0] op_slti    = 6'b001010;
    localparam logic [5:0] op_andi    = 6'b001100;
    localparam logic [5:0] op_ori     = 6'b001101;
    localparam logic [5:0] op_xori    = 6'b001110;
    localparam logic [5:0] op_lui     = 6'b001111;

    localparam logic [5:0] fn_addu = 6'b100001;
    localparam logic [5:0] fn_and  = 6'b100100;
    localparam logic [5:0] fn_or   = 6'b100101;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] predict_pc_addr;
        logic        predict_brunch_taken;
    } DECODE_REQUIRE;

    typedef struct packed {
        exe_type_t    exe_type;
        brunch_type_t brunch_type;
        alu_op_t      alu_op;
        llu_op_t      llu_op;
        logic         num1_need;
        logic [4:0]   num1_addr;
        logic [31:0]  num1;
        logic         num2_need;
        logic [4:0]   num2_addr;
        logic [31:0]  num2;
        logic         write_reg_need;
        logic [4:0]   write_reg_addr;
        logic [15:0]  memory_addr_offset;
        logic         mem_read_need;
        logic         mem_write_need;
        mem_type_t    mem_type;
        logic [2:0]   accept_mask;
        logic [31:0]  predict_pc_addr;
        logic         predict_brunch_taken;
    } ISSUE_QUEUE_ELEMENT;

    // Encoding used for empty lanes and undecodable instructions.
    function automatic ISSUE_QUEUE_ELEMENT default_elem();
        ISSUE_QUEUE_ELEMENT e;
        e = '0;
        e.exe_type    = arithmatic;
        e.brunch_type = nbc;
        e.alu_op      = alu_or;
        e.llu_op      = llu_nop;
        e.mem_type    = wrd;
        return e;
    endfunction

endpackage

// File: rtl/decode_unit_lane.sv
// Combinational single-lane decode. R-type (SPECIAL) decode is compiled in
// only when DECODE_RTYPE_EN is defined; otherwise opcode 000000 is illegal.
module decode_lane
    import decode_unit_pkg::*;
(
    input  DECODE_REQUIRE      req_i,
    input  logic               lane_valid_i,
    output ISSUE_QUEUE_ELEMENT elem_o,
    output logic               illegal_o
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        known;
    ISSUE_QUEUE_ELEMENT e;

    assign op  = req_i.inst[31:26];
    assign rs  = req_i.inst[25:21];
    assign rt  = req_i.inst[20:16];
    assign imm = req_i.inst[15:0];

`ifdef DECODE_RTYPE_EN
    logic [4:0] rd;
    logic [5:0] funct;
    assign rd    = req_i.inst[15:11];
    assign funct = req_i.inst[5:0];
`endif

    always_comb begin
        e                = default_elem();
        known            = 1'b1;
        e.accept_mask    = 3'b111;
        e.num1_need      = 1'b1;
        e.num1_addr      = rs;
        e.write_reg_need = 1'b1;
        e.write_reg_addr = rt;
        case (op)
            op_ori:   begin e.alu_op = alu_or;  e.num2 = {16'h0000, imm}; end
            op_andi:  begin e.alu_op = alu_and; e.num2 = {16'h0000, imm}; end
            op_xori:  begin e.alu_op = alu_xor; e.num2 = {16'h0000, imm}; end
            op_addiu: begin e.alu_op = alu_add; e.num2 = {{16{imm[15]}}, imm}; end
            op_slti:  begin e.alu_op = alu_slt; e.num2 = {{16{imm[15]}}, imm}; end
            op_lui: begin
                e.alu_op    = alu_or;
                e.num1_need = 1'b0;
                e.num1_addr = 5'd0;
                e.num2      = {imm, 16'h0000};
            end
`ifdef DECODE_RTYPE_EN
            op_special: begin
                e.num2_need      = 1'b1;
                e.num2_addr      = rt;
                e.write_reg_addr = rd;
                case (funct)
                    fn_addu: e.alu_op = alu_add;
                    fn_or:   e.alu_op = alu_or;
                    fn_and:  e.alu_op = alu_and;
                    default: known = 1'b0;
                endcase
            end
`endif
            default: known = 1'b0;
        endcase
        // Writes to $0 are architecturally discarded, so never request them.
        if (e.write_reg_addr == 5'd0) e.write_reg_need = 1'b0;
        if (!known || !lane_valid_i) e = default_elem();
        if (lane_valid_i) begin
            e.predict_pc_addr      = req_i.predict_pc_addr;
            e.predict_brunch_taken = req_i.predict_brunch_taken;
        end
        elem_o    = e;
        illegal_o = lane_valid_i && !known;
    end

endmodule

// File: rtl/decode_unit.sv
// Multi-lane decode stage: per-lane decode, registered output and a one-bundle
// skid buffer so in_ready is a flop. Optional macro: DECODE_RTYPE_EN.
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter int DECODE_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  DECODE_REQUIRE      [DECODE_WIDTH-1:0]  in_req,
    input  logic               [DECODE_WIDTH-1:0]  in_lane_valid,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output ISSUE_QUEUE_ELEMENT [DECODE_WIDTH-1:0]  out_elem,
    output logic               [DECODE_WIDTH-1:0]  out_lane_valid,
    output logic               [DECODE_WIDTH-1:0]  out_illegal
);

    ISSUE_QUEUE_ELEMENT [DECODE_WIDTH-1:0] dec_elem;
    logic               [DECODE_WIDTH-1:0] dec_illegal;

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
        decode_lane u_lane (
            .req_i        (in_req[i]),
            .lane_valid_i (in_lane_valid[i]),
            .elem_o       (dec_elem[i]),
            .illegal_o    (dec_illegal[i])
        );
    end

    logic                                  out_valid_q, out_valid_d;
    ISSUE_QUEUE_ELEMENT [DECODE_WIDTH-1:0] out_elem_q, out_elem_d;
    logic               [DECODE_WIDTH-1:0] out_lv_q, out_lv_d;
    logic               [DECODE_WIDTH-1:0] out_ill_q, out_ill_d;
    logic                                  skid_valid_q, skid_valid_d;
    ISSUE_QUEUE_ELEMENT [DECODE_WIDTH-1:0] skid_elem_q, skid_elem_d;
    logic               [DECODE_WIDTH-1:0] skid_lv_q, skid_lv_d;
    logic               [DECODE_WIDTH-1:0] skid_ill_q, skid_ill_d;
    logic                                  in_ready_q, in_ready_d;
    logic                                  in_fire;

    assign in_fire = in_valid && in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_elem_d   = out_elem_q;
        out_lv_d     = out_lv_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_elem_d  = skid_elem_q;
        skid_lv_d    = skid_lv_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: skid (older) wins, otherwise bypass input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_elem_d   = skid_elem_q;
                out_lv_d     = skid_lv_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_elem_d  = dec_elem;
                out_lv_d    = in_lane_valid;
                out_ill_d   = dec_illegal;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_elem_d  = dec_elem;
            skid_lv_d    = in_lane_valid;
            skid_ill_d   = dec_illegal;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_elem_q   <= '0;
            out_lv_q     <= '0;
            out_ill_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_elem_q  <= '0;
            skid_lv_q    <= '0;
            skid_ill_q   <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_elem_q   <= out_elem_d;
            out_lv_q     <= out_lv_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_elem_q  <= skid_elem_d;
            skid_lv_q    <= skid_lv_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_elem       = out_elem_q;
    assign out_lane_valid = out_lv_q;
    assign out_illegal    = out_ill_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed testbench for decode_unit (DECODE_WIDTH=2): decode fields,
// boundary cases, back-to-back flow, backpressure/skid, flush and reset.
module tb_decode_unit;
    import decode_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    DECODE_REQUIRE      [1:0] in_req;
    logic               [1:0] in_lane_valid, out_lane_valid, out_illegal;
    ISSUE_QUEUE_ELEMENT [1:0] out_elem;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    decode_unit #(.DECODE_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_req         (in_req),
        .in_lane_valid  (in_lane_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_elem       (out_elem),
        .out_lane_valid (out_lane_valid),
        .out_illegal    (out_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] lv);
        in_req[0].inst                 = i0;
        in_req[0].predict_pc_addr      = 32'h0000_1000;
        in_req[0].predict_brunch_taken = 1'b1;
        in_req[1].inst                 = i1;
        in_req[1].predict_pc_addr      = 32'h0000_1004;
        in_req[1].predict_brunch_taken = 1'b0;
        in_lane_valid                  = lv;
        in_valid                       = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(32'h3422_8001, 32'h0, 2'b01);
        repeat (3) step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        nvec++; if (out_elem !== '0) begin nerr++; $display("FAIL rst_out_elem got %h want 0", out_elem); end
        nvec++; if (out_lane_valid !== 2'b00 || out_illegal !== 2'b00) begin nerr++; $display("FAIL rst_lv_ill got %b/%b want 00/00", out_lane_valid, out_illegal); end
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_release_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_ori();
        drive(32'h3422_8001, 32'hFC00_0000, 2'b01);
        step();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL ori_valid got %b want 1", out_valid); end
        nvec++; if (out_elem[0].num2 !== 32'h0000_8001) begin nerr++; $display("FAIL ori_num2 got %h want 00008001", out_elem[0].num2); end
        nvec++; if (out_elem[0].alu_op !== alu_or) begin nerr++; $display("FAIL ori_alu got %0d want %0d", out_elem[0].alu_op, alu_or); end
        nvec++; if (out_elem[0].write_reg_need !== 1'b1 || out_elem[0].write_reg_addr !== 5'd2) begin nerr++; $display("FAIL ori_dest got %b/%0d want 1/2", out_elem[0].write_reg_need, out_elem[0].write_reg_addr); end
        nvec++; if (out_elem[0].num1_need !== 1'b1 || out_elem[0].num1_addr !== 5'd1 || out_elem[0].num2_need !== 1'b0) begin nerr++; $display("FAIL ori_srcs got %b/%0d/%b want 1/1/0", out_elem[0].num1_need, out_elem[0].num1_addr, out_elem[0].num2_need); end
        nvec++; if (out_elem[0].predict_pc_addr !== 32'h0000_1000 || out_elem[0].predict_brunch_taken !== 1'b1) begin nerr++; $display("FAIL ori_pred got %h/%b want 00001000/1", out_elem[0].predict_pc_addr, out_elem[0].predict_brunch_taken); end
        nvec++; if (out_illegal !== 2'b00 || out_lane_valid !== 2'b01) begin nerr++; $display("FAIL ori_ill_lv got %b/%b want 00/01", out_illegal, out_lane_valid); end
        nvec++; if (out_elem[1].alu_op !== alu_or || out_elem[1].num1_need !== 1'b0 || out_elem[1].write_reg_need !== 1'b0 || out_elem[1].num2 !== 32'h0) begin nerr++; $display("FAIL ori_lane1_default got %h want default", out_elem[1]); end
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL ori_drain got %b want 0", out_valid); end
    endtask

    task automatic test_addiu_lui();
        drive(32'h2403_FFFF, 32'h3C04_1234, 2'b11);
        step();
        in_valid = 1'b0;
        nvec++; if (out_elem[0].num2 !== 32'hFFFF_FFFF || out_elem[0].alu_op !== alu_add) begin nerr++; $display("FAIL addiu got %h/%0d want ffffffff/%0d", out_elem[0].num2, out_elem[0].alu_op, alu_add); end
        nvec++; if (out_elem[0].write_reg_addr !== 5'd3 || out_elem[0].write_reg_need !== 1'b1) begin nerr++; $display("FAIL addiu_dest got %0d want 3", out_elem[0].write_reg_addr); end
        nvec++; if (out_elem[1].num2 !== 32'h1234_0000 || out_elem[1].num1_need !== 1'b0 || out_elem[1].alu_op !== alu_or) begin nerr++; $display("FAIL lui got %h/%b want 12340000/0", out_elem[1].num2, out_elem[1].num1_need); end
        nvec++; if (out_elem[1].write_reg_addr !== 5'd4 || out_illegal !== 2'b00) begin nerr++; $display("FAIL lui_dest got %0d/%b want 4/00", out_elem[1].write_reg_addr, out_illegal); end
        step();
    endtask

    task automatic test_boundary();
        drive(32'hFC00_0000, 32'h2420_0005, 2'b11);
        step();
        nvec++; if (out_illegal !== 2'b01) begin nerr++; $display("FAIL bad_opcode_ill got %b want 01", out_illegal); end
        nvec++; if (out_elem[1].write_reg_need !== 1'b0 || out_elem[1].num2 !== 32'h5) begin nerr++; $display("FAIL rt0_wr got %b/%h want 0/5", out_elem[1].write_reg_need, out_elem[1].num2); end
        drive(32'h3422_0007, 32'hFC00_0000, 2'b01);
        step();
        in_valid = 1'b0;
        nvec++; if (out_illegal !== 2'b00 || out_lane_valid !== 2'b01) begin nerr++; $display("FAIL invalid_lane_ill got %b/%b want 00/01", out_illegal, out_lane_valid); end
        nvec++; if (out_elem[0].alu_op !== alu_or || out_elem[0].num2 !== 32'h7) begin nerr++; $display("FAIL invalid_lane_l0 got %h want 7", out_elem[0].num2); end
        step();
    endtask

    task automatic test_rtype();
        drive(32'h0022_1821, 32'h0, 2'b01);
        step();
        in_valid = 1'b0;
`ifdef DECODE_RTYPE_EN
        nvec++; if (out_illegal !== 2'b00 || out_elem[0].alu_op !== alu_add) begin nerr++; $display("FAIL addu got %b/%0d want 00/%0d", out_illegal, out_elem[0].alu_op, alu_add); end
        nvec++; if (out_elem[0].write_reg_addr !== 5'd3 || out_elem[0].num2_need !== 1'b1 || out_elem[0].num2_addr !== 5'd2) begin nerr++; $display("FAIL addu_regs got %0d/%0d want 3/2", out_elem[0].write_reg_addr, out_elem[0].num2_addr); end
`else
        nvec++; if (out_illegal !== 2'b01) begin nerr++; $display("FAIL addu_off_ill got %b want 01", out_illegal); end
        nvec++; if (out_elem[0].write_reg_need !== 1'b0 || out_elem[0].num1_need !== 1'b0) begin nerr++; $display("FAIL addu_off_default got %b/%b want 0/0", out_elem[0].write_reg_need, out_elem[0].num1_need); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive(32'h3422_0000 | k, 32'h0, 2'b01);
            step();
            nvec++; if (out_valid !== 1'b1 || out_elem[0].num2 !== k) begin nerr++; $display("FAIL b2b_%0d got %b/%h want 1/%h", k, out_valid, out_elem[0].num2, k); end
            nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready_%0d got %b want 1", k, in_ready); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(32'h3422_0011, 32'h0, 2'b01);
        step();
        nvec++; if (out_elem[0].num2 !== 32'h11 || in_ready !== 1'b1) begin nerr++; $display("FAIL bp_a got %h/%b want 11/1", out_elem[0].num2, in_ready); end
        drive(32'h3422_0022, 32'h0, 2'b01);
        step();
        nvec++; if (out_elem[0].num2 !== 32'h11 || in_ready !== 1'b0) begin nerr++; $display("FAIL bp_skid got %h/%b want 11/0", out_elem[0].num2, in_ready); end
        drive(32'h3422_0033, 32'h0, 2'b01);
        step();
        step();
        nvec++; if (out_valid !== 1'b1 || out_elem[0].num2 !== 32'h11 || in_ready !== 1'b0) begin nerr++; $display("FAIL bp_hold got %b/%h/%b want 1/11/0", out_valid, out_elem[0].num2, in_ready); end
        out_ready = 1'b1;
        step();
        nvec++; if (out_elem[0].num2 !== 32'h22 || in_ready !== 1'b1) begin nerr++; $display("FAIL bp_b got %h/%b want 22/1", out_elem[0].num2, in_ready); end
        step();
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1 || out_elem[0].num2 !== 32'h33) begin nerr++; $display("FAIL bp_c got %b/%h want 1/33", out_valid, out_elem[0].num2); end
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'h3422_0044, 32'h0, 2'b01);
        step();
        drive(32'h3422_0055, 32'h0, 2'b01);
        step();
        drive(32'h3422_0066, 32'h0, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL flush got %b/%b want 0/1", out_valid, in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_dropped got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        drive(32'h3422_0077, 32'h0, 2'b01);
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_elem !== '0) begin nerr++; $display("FAIL midrst got %b/%b want 0/0", out_valid, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_release got %b/%b want 1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_addiu_lui();
        test_boundary();
        test_rtype();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
